addroundkey_module: RTL and testbench

ADDROUNDKEY_MODULE -- requirements
Module: addroundkey_module

---
 rtl/aes_pkg.sv | 22 ++
 rtl/addroundkey_module_gf_adder.sv | 10 +
 rtl/addroundkey_module.sv | 175 +++++++++++++++++
 tb/tb_addroundkey_module.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AddRoundKey block: FSM encoding, word geometry
// and the parity helper used by the optional ADDROUNDKEY_PARITY_EN output.
package aes_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int KIDX_W    = 2;
    localparam int BYTE_W    = 8;

    localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FINISH = 2'd2
    } ark_state_t;

    function automatic logic word_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/addroundkey_module_gf_adder.sv
// GF(2^8) addition of two bytes; in this field addition is a plain XOR.
module GF_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o
);

    assign sum_o = a_i ^ b_i;

endmodule

// File: rtl/addroundkey_module.sv
// AES AddRoundKey: captures a 4-column state, fetches one round-key word per
// column over a stallable handshake, and XORs them. Optional par_out under ADDROUNDKEY_PARITY_EN.
module addroundkey_module
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_W-1:0]    statew1,
    input  logic [WORD_W-1:0]    statew2,
    input  logic [WORD_W-1:0]    statew3,
    input  logic [WORD_W-1:0]    statew4,
    output logic                 key_req,
    output logic [KIDX_W-1:0]    key_idx,
    input  logic                 key_valid,
    input  logic [WORD_W-1:0]    key_word,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_W-1:0]    new_statew1,
    output logic [WORD_W-1:0]    new_statew2,
    output logic [WORD_W-1:0]    new_statew3,
    output logic [WORD_W-1:0]    new_statew4
`ifdef ADDROUNDKEY_PARITY_EN
    ,
    output logic [NUM_WORDS-1:0] par_out
`endif
);

    ark_state_t           state_q, state_d;
    logic [KIDX_W-1:0]    idx_q, idx_d;
    logic                 armed_q, armed_d;
    logic [WORD_W-1:0]    cap_q [NUM_WORDS];
    logic [WORD_W-1:0]    cap_d [NUM_WORDS];
    logic [WORD_W-1:0]    res_q [NUM_WORDS];
    logic [WORD_W-1:0]    res_d [NUM_WORDS];
    logic [WORD_W-1:0]    out_q [NUM_WORDS];
    logic [WORD_W-1:0]    out_d [NUM_WORDS];

    logic                 capture;
    logic                 accept;
    logic                 last_word;
    logic [WORD_W-1:0]    sel_word;
    logic [WORD_W-1:0]    xor_word;

    assign capture   = (state_q == IDLE) && start && armed_q;
    // Dropping start in FETCH aborts, so a simultaneous key_valid is not accepted.
    assign accept    = (state_q == FETCH) && start && key_valid;
    assign last_word = accept && (idx_q == LAST_IDX);
    assign sel_word  = cap_q[idx_q];

    for (genvar b = 0; b < NUM_WORDS; b++) begin : g_byte
        GF_adder u_gf_adder (
            .a_i   (sel_word[b*BYTE_W +: BYTE_W]),
            .b_i   (key_word[b*BYTE_W +: BYTE_W]),
            .sum_o (xor_word[b*BYTE_W +: BYTE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            armed_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                cap_q[i] <= '0;
                res_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && armed_q) state_d = FETCH;
            end
            FETCH: begin
                if (!start)                                  state_d = IDLE;
                else if (key_valid && (idx_q == LAST_IDX))   state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        key_req = 1'b0;
        key_idx = '0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            FETCH: begin
                key_req = 1'b1;
                key_idx = idx_q;
                busy    = 1'b1;
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                key_req = 1'b0;
            end
        endcase
    end

    always_comb begin
        armed_d = armed_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        res_d   = res_q;
        out_d   = out_q;

        if (!start)       armed_d = 1'b1;
        else if (capture) armed_d = 1'b0;

        if (capture) begin
            idx_d    = '0;
            cap_d[0] = statew1;
            cap_d[1] = statew2;
            cap_d[2] = statew3;
            cap_d[3] = statew4;
        end

        if (accept) begin
            res_d[idx_q] = xor_word;
            if (!last_word) idx_d = idx_q + KIDX_W'(1);
        end

        // Outputs are loaded on the edge into FINISH so they are valid while done is high.
        if (last_word) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                out_d[i] = (KIDX_W'(i) == idx_q) ? xor_word : res_q[i];
            end
        end
    end

    assign new_statew1 = out_q[0];
    assign new_statew2 = out_q[1];
    assign new_statew3 = out_q[2];
    assign new_statew4 = out_q[3];

`ifdef ADDROUNDKEY_PARITY_EN
    logic [NUM_WORDS-1:0] par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (last_word) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                par_d[i] = word_parity(out_d[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) par_q <= '0;
        else     par_q <= par_d;
    end

    assign par_out = par_q;
`endif

endmodule

// File: tb/tb_addroundkey_module.sv
// Scoreboard bench for addroundkey_module: driver pushes expected XOR results,
// a done-triggered monitor pops and compares. Define ADDROUNDKEY_PARITY_EN to cover par_out.
module tb_addroundkey_module;

    typedef logic [3:0][31:0] blk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] statew1, statew2, statew3, statew4;
    logic        key_req;
    logic [1:0]  key_idx;
    logic        key_valid;
    logic [31:0] key_word;
    logic        busy;
    logic        done;
    logic [31:0] new_statew1, new_statew2, new_statew3, new_statew4;
`ifdef ADDROUNDKEY_PARITY_EN
    logic [3:0]  par_out;
`endif

    int   checks = 0;
    int   errors = 0;
    blk_t exp_q[$];

    always #5 clk = ~clk;

    addroundkey_module dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .statew1     (statew1),
        .statew2     (statew2),
        .statew3     (statew3),
        .statew4     (statew4),
        .key_req     (key_req),
        .key_idx     (key_idx),
        .key_valid   (key_valid),
        .key_word    (key_word),
        .busy        (busy),
        .done        (done),
        .new_statew1 (new_statew1),
        .new_statew2 (new_statew2),
        .new_statew3 (new_statew3),
        .new_statew4 (new_statew4)
`ifdef ADDROUNDKEY_PARITY_EN
        ,
        .par_out     (par_out)
`endif
    );

    function automatic blk_t mk(input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] w3, input logic [31:0] w4);
        blk_t b;
        b[0] = w1; b[1] = w2; b[2] = w3; b[3] = w4;
        return b;
    endfunction

    function automatic blk_t rnd_blk();
        return mk($urandom, $urandom, $urandom, $urandom);
    endfunction

    function automatic logic [3:0] par4(input blk_t b);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^b[i];
        return p;
    endfunction

    function automatic blk_t outs();
        return mk(new_statew1, new_statew2, new_statew3, new_statew4);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        blk_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no operation pending");
            end else begin
                e = exp_q.pop_front();
                chk("result", outs(), e);
`ifdef ADDROUNDKEY_PARITY_EN
                chk("parity", par_out, par4(e));
`endif
            end
        end
    end

    // Full operation; stall<0 picks a random 0..2 idle cycles before each key word.
    task automatic do_op(input blk_t st, input blk_t k, input int stall, output int lat);
        int sc;
        int nwords;
        @(negedge clk);
        start = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        statew1 = st[0]; statew2 = st[1]; statew3 = st[2]; statew4 = st[3];
        start = 1'b1;
        exp_q.push_back(st ^ k);
        sc = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        nwords = 0;
        lat = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            key_valid = 1'b0;
            if (key_req === 1'b1) begin
                if (sc > 0) begin
                    sc--;
                end else begin
                    chk("key_idx_seq", key_idx, nwords);
                    key_valid = 1'b1;
                    key_word = k[key_idx];
                    nwords++;
                    sc = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                end
            end
        end
        key_valid = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no done within 200 cycles expected done");
            exp_q.delete();
        end
    endtask

    // Start an operation, supply `words` key words, then drop start with key_valid high.
    task automatic do_abort(input blk_t st, input blk_t k, input int words);
        int nwords;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        statew1 = st[0]; statew2 = st[1]; statew3 = st[2]; statew4 = st[3];
        start = 1'b1;
        nwords = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (key_req === 1'b1) begin
                key_valid = 1'b1;
                key_word = k[key_idx];
                if (nwords == words) begin
                    start = 1'b0;
                    break;
                end
                nwords++;
            end
        end
        @(negedge clk);
        chk("abort_idle", {busy, key_req, done}, 3'b000);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {key_req, busy, done, key_idx}, 5'd0);
        chk({name, "_data"}, outs(), '0);
`ifdef ADDROUNDKEY_PARITY_EN
        chk({name, "_par"}, par_out, 4'b0000);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t fips_st, fips_k, fips_r, zero_k, st, k, prev;
        int   lat;

        fips_st = mk(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        fips_k  = mk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);
        fips_r  = mk(32'h00102030, 32'h40506070, 32'h8090a0b0, 32'hc0d0e0f0);
        zero_k  = '0;

        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_word = '0;
        statew1 = '0; statew2 = '0; statew3 = '0; statew4 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // FIPS-197 vector, continuous key_valid
        do_op(fips_st, fips_k, 0, lat);
        chk("fips_latency", lat, 5);
        chk("fips_value", outs(), fips_r);
`ifdef ADDROUNDKEY_PARITY_EN
        chk("fips_par", par_out, 4'b0000);
`endif

        // Three stall cycles before every word
        do_op(fips_st, fips_k, 3, lat);
        chk("stall_latency", lat, 17);

        // start stays high after done: no re-trigger, outputs hold
        repeat (6) begin
            @(negedge clk);
            chk("no_retrigger", {busy, key_req}, 2'b00);
        end
        chk("hold_after_done", outs(), fips_r);

        // zero key returns the state unchanged
        st = rnd_blk();
        do_op(st, zero_k, 0, lat);
        chk("zero_key", outs(), st);
        prev = st;

        // abort after key word 1
        do_abort(rnd_blk(), rnd_blk(), 2);
        chk("abort_hold", outs(), prev);

        // reset in the middle of FETCH, start kept high afterwards
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        statew1 = $urandom; statew2 = $urandom; statew3 = $urandom; statew4 = $urandom;
        start = 1'b1;
        repeat (2) @(negedge clk);
        key_valid = 1'b1;
        key_word = $urandom;
        @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_fetch_reset");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_capture_after_reset", {busy, key_req}, 2'b00);
        end

        // randomized operations with random stalls
        for (int n = 0; n < 20; n++) begin
            st = rnd_blk();
            k = rnd_blk();
            do_op(st, k, -1, lat);
            chk("rand_latency_min", (lat >= 5), 1'b1);
            if (n % 5 == 4) begin
                prev = outs();
                do_abort(rnd_blk(), rnd_blk(), int'($urandom_range(0, 3)));
                chk("rand_abort_hold", outs(), prev);
            end
        end

`ifdef ADDROUNDKEY_PARITY_EN
        do_op(mk(32'hffffffff, 32'h00000000, 32'h00000001, 32'h00000000), zero_k, 0, lat);
        chk("par_vector", par_out, 4'b0100);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
